// File: rtl/data_sram_responder.sv
// Data-side memory for the 5-stage CPU: word RAM plus LED/switch/timer/scratch confreg, 1-cycle reads.
// Optional feature macro: DSRAM_RESP_TIMER_EN (free-running TIMER register at offset 0x0008).
module data_sram_responder #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out
);

    typedef enum logic [15:0] {
        OFF_LED     = 16'h0000,
        OFF_SWITCH  = 16'h0004,
        OFF_TIMER   = 16'h0008,
        OFF_SCRATCH = 16'h000C
    } conf_off_e;

    logic [31:0]       ram [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] ram_idx;
    logic              conf_sel;
    logic              rd_req;
    logic              wr_req;
    logic              conf_we;
    logic [31:0]       lane_mask;
    logic [31:0]       conf_rd;
    logic [15:0]       led_q;
    logic [31:0]       scratch_q;
    logic [31:0]       timer_q;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic              unused;

    assign conf_sel  = (data_sram_addr[31:16] == CONF_HI);
    assign ram_idx   = data_sram_addr[ADDR_W+1:2];
    assign rd_req    = data_sram_en && (data_sram_wen == 4'b0000);
    assign wr_req    = data_sram_en && (data_sram_wen != 4'b0000);
    assign conf_we   = wr_req && conf_sel;
    assign lane_mask = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                        {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};
    assign unused    = ^data_sram_addr[1:0];

    // NOTE: the RAM array has no reset; only its write is gated so accesses during reset are dropped.
    always_ff @(posedge clk) begin
        if (resetn && wr_req && !conf_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns conf_rd and no latch is inferred.
        conf_rd = 32'h0;
        case (data_sram_addr[15:0])
            OFF_LED:     conf_rd = {16'h0, led_q};
            OFF_SWITCH:  conf_rd = {16'h0, sw_sync};
            OFF_TIMER:   conf_rd = timer_q;
            OFF_SCRATCH: conf_rd = scratch_q;
            default:     conf_rd = 32'h0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so reads see pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
            led_q           <= 16'h0;
            scratch_q       <= 32'h0;
            sw_meta         <= 16'h0;
            sw_sync         <= 16'h0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
            if (rd_req) data_sram_rdata <= conf_sel ? conf_rd : ram[ram_idx];
            if (conf_we && data_sram_addr[15:0] == OFF_LED)
                led_q <= (led_q & ~lane_mask[15:0]) | (data_sram_wdata[15:0] & lane_mask[15:0]);
            if (conf_we && data_sram_addr[15:0] == OFF_SCRATCH)
                scratch_q <= (scratch_q & ~lane_mask) | (data_sram_wdata & lane_mask);
        end
    end

`ifdef DSRAM_RESP_TIMER_EN
    logic [31:0] timer_inc;
    assign timer_inc = timer_q + 32'd1;

    // Written lanes take wdata; untouched lanes still advance with the increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= 32'h0;
        end else if (conf_we && data_sram_addr[15:0] == OFF_TIMER) begin
            timer_q <= (timer_inc & ~lane_mask) | (data_sram_wdata & lane_mask);
        end else begin
            timer_q <= timer_inc;
        end
    end
`else
    assign timer_q = 32'h0;
`endif

    assign led_out = led_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with a per-cycle behavioural reference.
module tb_data_sram_responder;
    localparam int ADDR_W = 10;
    localparam logic [31:0] A_LED  = 32'hBFAF_0000;
    localparam logic [31:0] A_SW   = 32'hBFAF_0004;
    localparam logic [31:0] A_TMR  = 32'hBFAF_0008;
    localparam logic [31:0] A_SCR  = 32'hBFAF_000C;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [15:0] switch_in = 16'h0;
    logic [31:0] rdata;
    logic [15:0] led_out;

    int checks = 0;
    int errors = 0;

    data_sram_responder #(.ADDR_W(ADDR_W), .CONF_HI(16'hBFAF)) dut (
        .clk(clk), .resetn(resetn),
        .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_rdata(rdata),
        .switch_in(switch_in), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what the memory map must hold after each edge.
    logic [31:0] m_mem [int];
    logic [31:0] m_rdata = 32'h0;
    logic [15:0] m_led = 16'h0;
    logic [31:0] m_timer = 32'h0;
    logic [31:0] m_scratch = 32'h0;
    logic [15:0] m_sw [2] = '{16'h0, 16'h0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] w);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << ADDR_W));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:16] != 16'hBFAF) return m_mem.exists(word_of(a)) ? m_mem[word_of(a)] : 32'hx;
        case (a[15:0])
            16'h0000: return {16'h0, m_led};
            16'h0004: return {16'h0, m_sw[1]};
`ifdef DSRAM_RESP_TIMER_EN
            16'h0008: return m_timer;
`endif
            16'h000C: return m_scratch;
            default:  return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_rdata = 0; m_led = 0; m_timer = 0; m_scratch = 0; m_sw = '{16'h0, 16'h0};
            end else begin
                logic [31:0] t_next, tmp;
                t_next = m_timer + 1;
                if (en && wen == 4'h0) m_rdata = model_read(addr);
                if (en && wen != 4'h0) begin
                    if (addr[31:16] == 16'hBFAF) begin
                        case (addr[15:0])
                            16'h0000: begin tmp = merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
                            16'h0008: t_next = merge(t_next, wdata, wen);
                            16'h000C: m_scratch = merge(m_scratch, wdata, wen);
                            default: ;
                        endcase
                    end else begin
                        tmp = m_mem.exists(word_of(addr)) ? m_mem[word_of(addr)] : 32'hx;
                        m_mem[word_of(addr)] = merge(tmp, wdata, wen);
                    end
                end
`ifdef DSRAM_RESP_TIMER_EN
                m_timer = t_next;
`endif
                m_sw[1] = m_sw[0];
                m_sw[0] = switch_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("rdata_vs_model", rdata, m_rdata);
            check("led_vs_model", {16'h0, led_out}, {16'h0, m_led});
        end
    end

    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(negedge clk);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        cyc(1'b1, w, a, d);
    endtask
    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 4'h0, a, 32'h0);
    endtask
    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led_out}, 32'h0);
        resetn = 1'b1;

        wr(32'h10, 32'h1122_3344, 4'hF);
        rd(32'h10);
        check("ram_full_write", rdata, 32'h1122_3344);
        wr(32'h10, 32'hAABB_CCDD, 4'b0101);
        rd(32'h10);
        check("ram_lane_merge", rdata, 32'h11BB_33DD);
        idle();
        wr(32'h20, 32'h0000_0001, 4'hF);
        check("rdata_hold", rdata, 32'h11BB_33DD);
        wr(32'h0, 32'hCAFE_F00D, 4'hF);
        rd(32'h1000);
        check("ram_alias", rdata, 32'hCAFE_F00D);
        wr(32'hBFAE_0010, 32'h0BAD_F00D, 4'hF);
        rd(32'h10);
        check("near_conf_goes_to_ram", rdata, 32'h0BAD_F00D);

        wr(A_LED, 32'h0000_A5A5, 4'hF);
        check("led_write", {16'h0, led_out}, 32'h0000_A5A5);
        rd(A_LED);
        check("led_read", rdata, 32'h0000_A5A5);
        wr(A_LED, 32'hFFFF_3C00, 4'b1010);
        rd(A_LED);
        check("led_lane_upper_zero", rdata, 32'h0000_3CA5);

        switch_in = 16'h5A3C;
        idle();
        wr(A_SW, 32'h0000_1234, 4'hF);
        rd(A_SW);
        check("switch_read_only", rdata, 32'h0000_5A3C);
        switch_in = 16'hC3C3;
        rd(A_SW);
        check("switch_sync_old0", rdata, 32'h0000_5A3C);
        rd(A_SW);
        rd(A_SW);
        check("switch_sync_new", rdata, 32'h0000_C3C3);

        wr(32'hBFAF_0010, 32'hFFFF_FFFF, 4'hF);
        rd(32'hBFAF_0010);
        check("unmapped_offset", rdata, 32'h0);

        wr(A_TMR, 32'hFFFF_FFFE, 4'hF);
        idle();
        idle();
        rd(A_TMR);
        check("timer_wrap0", rdata, 32'h0);
        rd(A_TMR);
`ifdef DSRAM_RESP_TIMER_EN
        check("timer_wrap1", rdata, 32'h1);
`else
        check("timer_absent", rdata, 32'h0);
`endif
        wr(A_TMR, 32'h1200_0000, 4'b1000);
        rd(A_TMR);

        wr(A_SCR, 32'hDEAD_BEEF, 4'hF);
        rd(A_SCR);
        check("scratch_read", rdata, 32'hDEAD_BEEF);

        en = 1'b1; wen = 4'h0; addr = A_LED;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_reset_rdata", rdata, 32'h0);
        check("async_reset_led", {16'h0, led_out}, 32'h0);
        wr(A_SCR, 32'h5555_5555, 4'hF);
        wr(A_LED, 32'h0000_FFFF, 4'hF);
        resetn = 1'b1;
        rd(A_SCR);
        check("scratch_after_reset", rdata, 32'h0);
        rd(A_LED);
        check("led_after_reset", rdata, 32'h0);
        idle();

        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
